// File: rtl/fetch_stage_if.sv
// Fetch-stage handshake bundle: instruction-memory port, hazard/control
// inputs, and the F/D register outputs consumed by decode.
interface fetch_stage_if;
   logic        ihit;
   logic [31:0] imemload;
   logic        pcEN;
   logic        fdEN;
   logic        fd_flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] fd_instr;
   logic [31:0] fd_npc;
   logic        fd_valid;

   // Fetch stage view
   modport master (
      input  ihit, imemload, pcEN, fdEN, fd_flush, redirect, redirect_pc, halt,
      output imemREN, imemaddr, fd_instr, fd_npc, fd_valid
   );

   // Environment view (memory, hazard unit, control, decode)
   modport slave (
      output ihit, imemload, pcEN, fdEN, fd_flush, redirect, redirect_pc, halt,
      input  imemREN, imemaddr, fd_instr, fd_npc, fd_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus F/D pipeline register for the 5-stage MIPS.
// Owns the PC, holds an outstanding request address stable until ihit,
// and parks a redirect target while a wrong-path request is in flight.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic           CLK,
   input  logic           RST,
   fetch_stage_if.master  bus
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_RWAIT  = 2'd1,
      S_HALTED = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_npc_q, fd_npc_d;
   logic        fd_valid_q, fd_valid_d;

   logic [31:0] pc_inc;
   logic [31:0] redir_masked;

   assign pc_inc       = pc_q + 32'd4;   // wraps modulo 2^32
   assign redir_masked = {bus.redirect_pc[31:2], 2'b00};

   assign bus.imemaddr = pc_q;
   assign bus.imemREN  = (state_q != S_HALTED);
   assign bus.fd_instr = fd_instr_q;
   assign bus.fd_npc   = fd_npc_q;
   assign bus.fd_valid = fd_valid_q;

   // Next-state: priority halt > redirect > flush > normal fetch
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      target_d   = target_q;
      fd_instr_d = fd_instr_q;
      fd_npc_d   = fd_npc_q;
      fd_valid_d = fd_valid_q;
      unique case (state_q)
         S_FETCH: begin
            if (bus.halt) begin
               fd_instr_d = '0;
               fd_npc_d   = '0;
               fd_valid_d = 1'b0;
               state_d    = S_HALTED;
            end else if (bus.redirect) begin
               fd_instr_d = '0;
               fd_npc_d   = '0;
               fd_valid_d = 1'b0;
               if (bus.ihit) begin
                  pc_d = redir_masked;
               end else begin
                  // Request at pc must stay stable until it returns
                  target_d = redir_masked;
                  state_d  = S_RWAIT;
               end
            end else if (bus.fd_flush) begin
               fd_instr_d = '0;
               fd_npc_d   = '0;
               fd_valid_d = 1'b0;
               if (bus.pcEN) pc_d = pc_inc;
            end else begin
               if (bus.pcEN) pc_d = pc_inc;
               if (bus.fdEN) begin
                  fd_instr_d = bus.imemload;
                  fd_npc_d   = pc_inc;
                  fd_valid_d = 1'b1;
               end
            end
         end
         S_RWAIT: begin
            // F/D stays empty; the returning word is wrong-path
            fd_instr_d = '0;
            fd_npc_d   = '0;
            fd_valid_d = 1'b0;
            if (bus.halt) begin
               state_d = S_HALTED;
            end else begin
               if (bus.redirect) target_d = redir_masked;
               if (bus.ihit) begin
                  pc_d    = bus.redirect ? redir_masked : target_q;
                  state_d = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            fd_instr_d = '0;
            fd_npc_d   = '0;
            fd_valid_d = 1'b0;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State and pipeline registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_FETCH;
         pc_q       <= PC_INIT;
         target_q   <= '0;
         fd_instr_q <= '0;
         fd_npc_q   <= '0;
         fd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         target_q   <= target_d;
         fd_instr_q <= fd_instr_d;
         fd_npc_q   <= fd_npc_d;
         fd_valid_q <= fd_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall,
// redirects with and without hit, flush, halt, reset recovery, PC wrap.
module tb_fetch_stage;

   logic clk;
   logic rst;
   int   tests;
   int   failed;

   fetch_stage_if bus ();

   fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_fd(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                         input logic vld);
      chk({tag, ".instr"}, bus.fd_instr, ins);
      chk({tag, ".npc"},   bus.fd_npc,   npc);
      chk({tag, ".valid"}, {31'd0, bus.fd_valid}, {31'd0, vld});
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      rst              = 1'b1;
      bus.ihit         = 1'b0;
      bus.imemload     = '0;
      bus.pcEN         = 1'b0;
      bus.fdEN         = 1'b0;
      bus.fd_flush     = 1'b0;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = '0;
      bus.halt         = 1'b0;

      // Reset state
      step();
      step();
      chk("rst.addr", bus.imemaddr, 32'h0);
      chk("rst.ren",  {31'd0, bus.imemREN}, 32'd1);
      chk_fd("rst", 32'h0, 32'h0, 1'b0);

      // Sequential fetch
      rst = 1'b0;
      bus.ihit = 1'b1; bus.pcEN = 1'b1; bus.fdEN = 1'b1;
      bus.imemload = 32'h2001_0005;
      step();
      chk("seq1.addr", bus.imemaddr, 32'h4);
      chk_fd("seq1", 32'h2001_0005, 32'h4, 1'b1);
      step();
      chk("seq2.addr", bus.imemaddr, 32'h8);
      chk_fd("seq2", 32'h2001_0005, 32'h8, 1'b1);

      // Load-use stall at pc=8
      bus.pcEN = 1'b0; bus.fdEN = 1'b0; bus.imemload = 32'hDEAD_BEEF;
      step();
      chk("stall.addr", bus.imemaddr, 32'h8);
      chk_fd("stall", 32'h2001_0005, 32'h8, 1'b1);
      bus.pcEN = 1'b1; bus.fdEN = 1'b1; bus.imemload = 32'h1111_1111;
      step();
      chk("resume.addr", bus.imemaddr, 32'hC);
      chk_fd("resume", 32'h1111_1111, 32'hC, 1'b1);

      // Redirect with hit: low bits dropped, returned word not latched
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0043; bus.imemload = 32'h2222_2222;
      step();
      chk("rhit.addr", bus.imemaddr, 32'h40);
      chk_fd("rhit", 32'h0, 32'h0, 1'b0);
      bus.redirect = 1'b0; bus.imemload = 32'h3333_3333;
      step();
      chk("rhit2.addr", bus.imemaddr, 32'h44);
      chk_fd("rhit2", 32'h3333_3333, 32'h44, 1'b1);

      // Move to pc=20, then redirect during a miss
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0014;
      step();
      chk("to20.addr", bus.imemaddr, 32'h14);
      bus.redirect_pc = 32'h0000_0100; bus.ihit = 1'b0;
      step();
      chk("rmiss.addr0", bus.imemaddr, 32'h14);
      chk("rmiss.valid0", {31'd0, bus.fd_valid}, 32'd0);
      bus.redirect = 1'b0;
      step();
      chk("rmiss.addr1", bus.imemaddr, 32'h14);
      chk("rmiss.valid1", {31'd0, bus.fd_valid}, 32'd0);
      step();
      chk("rmiss.addr2", bus.imemaddr, 32'h14);
      chk("rmiss.valid2", {31'd0, bus.fd_valid}, 32'd0);
      bus.ihit = 1'b1; bus.imemload = 32'h5555_5555;
      step();
      chk("rmiss.addr3", bus.imemaddr, 32'h100);
      chk_fd("rmiss3", 32'h0, 32'h0, 1'b0);
      bus.imemload = 32'h6666_6666;
      step();
      chk("rmiss.addr4", bus.imemaddr, 32'h104);
      chk_fd("rmiss4", 32'h6666_6666, 32'h104, 1'b1);

      // Flush overrides fdEN, PC still advances
      bus.fd_flush = 1'b1;
      step();
      chk("flush.addr", bus.imemaddr, 32'h108);
      chk_fd("flush", 32'h0, 32'h0, 1'b0);
      bus.fd_flush = 1'b0;
      step();
      chk("postflush.addr", bus.imemaddr, 32'h10C);
      chk_fd("postflush", 32'h6666_6666, 32'h10C, 1'b1);

      // Halt freezes fetch and ignores redirect
      bus.halt = 1'b1;
      step();
      chk("halt.ren",  {31'd0, bus.imemREN}, 32'd0);
      chk("halt.addr", bus.imemaddr, 32'h10C);
      chk_fd("halt", 32'h0, 32'h0, 1'b0);
      bus.halt = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0500;
      step();
      chk("halt2.ren",  {31'd0, bus.imemREN}, 32'd0);
      chk("halt2.addr", bus.imemaddr, 32'h10C);
      chk("halt2.valid", {31'd0, bus.fd_valid}, 32'd0);
      bus.redirect = 1'b0;

      // Reset leaves HALTED and restarts at PC_INIT
      rst = 1'b1;
      step();
      chk("rst2.addr", bus.imemaddr, 32'h0);
      chk("rst2.ren",  {31'd0, bus.imemREN}, 32'd1);
      rst = 1'b0; bus.imemload = 32'h7777_7777;
      step();
      chk("rst2.next", bus.imemaddr, 32'h4);
      chk_fd("rst2", 32'h7777_7777, 32'h4, 1'b1);

      // Wrap-around from 0xFFFF_FFFC
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
      step();
      chk("wrap.pc", bus.imemaddr, 32'hFFFF_FFFC);
      bus.redirect = 1'b0; bus.imemload = 32'h4444_4444;
      step();
      chk("wrap.addr", bus.imemaddr, 32'h0);
      chk_fd("wrap", 32'h4444_4444, 32'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
